uart_port_ctrl: RTL

//  Shares one uart instance between NUM_REQ transmit requesters with round-robin

---
 rtl/uart_port_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/uart_port_ctrl.sv
// uart_port_ctrl: round-robin TX arbitration onto one uart plus RX byte capture
// with valid/ready hand-off, busy-timeout and overrun flags.
module uart_port_ctrl #(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic                 clk_50m,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic                 tx_err,
  input  logic                 err_clr,
  output logic [7:0]           uart_din,
  output logic                 uart_wr_en,
  input  logic                 uart_tx_busy,
  input  logic [7:0]           uart_dout,
  input  logic                 uart_rdy,
  output logic                 uart_rdy_clr,
  output logic [7:0]           rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_overrun
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BUSY_TIMEOUT);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] BUSY = 2'd3;

  logic [1:0]         state;
  logic [PW-1:0]      ptr, off, gnt_idx, nxt_ptr;
  logic [PW:0]        sum;
  logic [NUM_REQ-1:0] rot, gnt_oh;
  logic [CW-1:0]      cnt;
  logic [7:0]         req_bytes [NUM_REQ];
  logic               found, grant, timeout, rdy_q, rise, ovr_hit;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign req_bytes[g] = req_data[8*g +: 8];
  end

  // rotate so bit 0 is the requester at ptr; lowest set bit wins
  assign rot = NUM_REQ'({req_valid, req_valid} >> ptr);

  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (rot[k]) begin
        found = 1'b1;
        off   = PW'(k);
      end
  end

  assign sum     = {1'b0, ptr} + {1'b0, off};
  assign gnt_idx = (sum >= (PW+1)'(NUM_REQ)) ? PW'(sum - (PW+1)'(NUM_REQ)) : sum[PW-1:0];
  assign nxt_ptr = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  assign gnt_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_idx;
  assign grant   = (state == IDLE) && found && !uart_tx_busy;
  // wr_en cycle plus BUSY_TIMEOUT-1 WAIT cycles without tx_busy
  assign timeout = (state == WAIT) && !uart_tx_busy && (cnt == CW'(BUSY_TIMEOUT - 2));

  always_ff @(posedge clk_50m or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      cnt        <= '0;
      uart_din   <= '0;
      uart_wr_en <= 1'b0;
      req_ack    <= '0;
      tx_err     <= 1'b0;
    end else begin
      req_ack    <= grant ? gnt_oh : '0;
      uart_wr_en <= grant;
      tx_err     <= timeout | (tx_err & ~err_clr);
      if (grant) begin
        uart_din <= req_bytes[gnt_idx];
        ptr      <= nxt_ptr;
      end
      case (state)
        IDLE:    state <= grant ? LOAD : IDLE;
        LOAD: begin
          state <= WAIT;
          cnt   <= '0;
        end
        WAIT: begin
          state <= uart_tx_busy ? BUSY : (timeout ? IDLE : WAIT);
          cnt   <= cnt + 1'b1;
        end
        default: state <= uart_tx_busy ? BUSY : IDLE;
      endcase
    end

  assign rise    = uart_rdy & ~rdy_q;
  assign ovr_hit = rise & rx_valid & ~rx_ready;

  always_ff @(posedge clk_50m or negedge rst_n)
    if (!rst_n) begin
      rdy_q        <= 1'b0;
      uart_rdy_clr <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      rdy_q        <= uart_rdy;
      uart_rdy_clr <= rise;
      rx_overrun   <= ovr_hit | (rx_overrun & ~err_clr);
      if (rise && !ovr_hit) begin
        rx_data  <= uart_dout;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
endmodule
